mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates between the pipeline's instruction-fetch and data-memory requests for a single-ported RAM. It sits between the datapath (fetch and the MEM stage) and the RAM. It grants one requester at a time and holds the grant until the access completes. Data has priority, and a bounded streak counter prevents fetch starvation.

## Interface
Parameters:
- MAX_DSTREAK, default 4: consecutive data completions allowed while fetch waits before fetch is forced to win. 0 disables the guard (strict data priority).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  fetch request.
- iaddr  in  32  fetch address.
- iload  out  32  fetch data; valid when iREN=1 and iwait=0.
- iwait  out  1  fetch not complete this cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read data; valid when dREN=1 and dwait=0.
- dwait  out  1  data access not complete this cycle.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM completes the presented access this cycle.

## Operation

Requester rules:
- A requester holds its enable, address and store data stable until its wait goes low, or until it withdraws the request.
- dreq = dREN | dWEN.
- If dREN and dWEN are both high, the access is a write: ramWEN=1, ramREN=0.

States:
- IDLE: no access is locked.
- LOCK_I: fetch holds the RAM.
- LOCK_D: data holds the RAM.

IDLE winner selection (combinational, same cycle):
- Only one requester active: it wins.
- Both active: data wins, unless MAX_DSTREAK≠0 and streak==MAX_DSTREAK; then fetch wins.
- No request: ram strobes are 0, and ramaddr/ramstore are 0.

RAM drive:
- The winner's (or locked owner's) enable, address and store data go to the ram* outputs.
- For fetch: ramREN=1, ramWEN=0, ramstore=0.

Transitions:
- IDLE, winner present, ramready=1: access completes this cycle; stay IDLE.
- IDLE, winner present, ramready=0: go to LOCK_I or LOCK_D.
- LOCK_x, ramready=1: go to IDLE.
- LOCK_x, owner withdraws its enable: drive ram strobes 0 that cycle; go to IDLE next edge; no completion is reported.
- LOCK_x, other requester arrives: it waits. A lock is never preempted.

Wait outputs:
- iwait = iREN & ~(fetch granted & ramready).
- dwait = dreq & ~(data granted & ramready).
- "Granted" means the IDLE winner or the LOCK owner.

Data outputs:
- iload = ramload and dload = ramload, unconditionally.

Streak counter:
- Width $clog2(MAX_DSTREAK+1), minimum 1.
- Data completion with iREN=1: increment, saturating at MAX_DSTREAK.
- Fetch completion: clear to 0.
- iREN=0 at an edge with no data completion: clear to 0.

## Timing
- Reset (async): state=IDLE, streak=0.
- During and immediately after reset, the ram* outputs follow the IDLE rules. With no requests they are all 0; iwait=iREN and dwait=dreq.
- Zero-wait RAM (ramready held high): a request completes in its request cycle. Back-to-back accesses complete one per cycle with no bubble.
- RAM with N cycles of ramready=0 then 1: completion N cycles after the request cycle. The wait output goes low in the ramready cycle.
- The state and streak registers are the only sequential elements. All outputs are combinational from the registers and inputs; none are registered.
- ramready while no strobe is asserted is ignored.
- Reset asserted mid-lock drops the lock immediately; no completion is reported.

## Test plan
- Zero-wait RAM, iREN=1 only, iaddr=0x40, ramload=0xDEADBEEF → same cycle ramREN=1, ramaddr=0x40, iwait=0, iload=0xDEADBEEF; state stays IDLE.
- RAM ready after 2 stall cycles, dWEN=1, daddr=0x100, dstore=0x1234, iREN also 1 → data wins; ramWEN=1 and ramaddr=0x100 for 3 cycles; dwait=0 in the third cycle; iwait=1 throughout; fetch is granted the following cycle.
- Lock then arrival: fetch locked with ramready=0, dREN raised → ramaddr stays = iaddr; dwait=1 until fetch completes; then data is served.
- Fairness, MAX_DSTREAK=4, zero-wait RAM, iREN and dREN held high → 4 data completions, then 1 fetch completion, repeating; streak sequence 1,2,3,4,0. With MAX_DSTREAK=0 → fetch never completes.
- Withdrawal: data locked with ramready=0, dREN dropped → that cycle ramREN=0 and ramWEN=0; next cycle IDLE; a pending iREN is granted.
- Async reset asserted while in LOCK_D → state IDLE with no clock edge; streak=0; dREN=0 and iREN=1 held after release → fetch granted immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and
// data memory. Data has priority. A saturating streak counter forces fetch
// to win after MAX_DSTREAK consecutive data completions while fetch waits.
// A grant is held (locked) until the RAM completes or the owner withdraws.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  localparam int SW = (MAX_DSTREAK == 0) ? 1 : $clog2(MAX_DSTREAK + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          iREN,
  input  logic [31:0]   iaddr,
  output logic [31:0]   iload,
  output logic          iwait,
  input  logic          dREN,
  input  logic          dWEN,
  input  logic [31:0]   daddr,
  input  logic [31:0]   dstore,
  output logic [31:0]   dload,
  output logic          dwait,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [31:0]   ramaddr,
  output logic [31:0]   ramstore,
  input  logic [31:0]   ramload,
  input  logic          ramready,
  output logic [1:0]    dbg_state_o,
  output logic [SW-1:0] dbg_streak_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  localparam logic [SW-1:0] MAX_S = SW'(MAX_DSTREAK);

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          dreq;
  logic          force_i;
  logic          grant_i, grant_d;
  logic          done_i, done_d;

  assign dreq    = dREN | dWEN;
  assign force_i = (MAX_DSTREAK != 0) && (streak_q == MAX_S);

  // State register; async reset drops any lock immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Streak register; async reset clears the fairness history.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= '0;
    else       streak_q <= streak_d;
  end

  // Next state: lock on a stalled grant, release on completion or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d && !ramready)      state_d = LOCK_D;
        else if (grant_i && !ramready) state_d = LOCK_I;
      end
      LOCK_I:  if (ramready || !iREN) state_d = IDLE;
      LOCK_D:  if (ramready || !dreq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pick the granted requester and route it to the RAM port.
  always_comb begin
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        grant_d = dreq && !(iREN && force_i);
        grant_i = iREN && !grant_d;
      end
      LOCK_I:  grant_i = iREN;
      LOCK_D:  grant_d = dreq;
      default: ;
    endcase
    if (grant_d) begin
      ramWEN   = dWEN;
      ramREN   = dREN & ~dWEN;
      ramaddr  = daddr;
      ramstore = dstore;
    end else if (grant_i) begin
      ramREN   = 1'b1;
      ramaddr  = iaddr;
    end
    done_i = grant_i & ramready;
    done_d = grant_d & ramready;
    iwait  = iREN & ~done_i;
    dwait  = dreq & ~done_d;
    iload  = ramload;
    dload  = ramload;
  end

  // Streak: count data wins while fetch waits; clear when fetch completes or leaves.
  always_comb begin
    streak_d = streak_q;
    if (done_d && iREN) begin
      if (streak_q != MAX_S) streak_d = streak_q + 1'b1;
    end else if (done_i) begin
      streak_d = '0;
    end else if (!iREN && !done_d) begin
      streak_d = '0;
    end
  end

  assign dbg_state_o  = state_q;
  assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed per-cycle vectors. The driver applies inputs and
// pushes the hand-computed expected outputs; a monitor pops and compares on
// the falling edge. A second instance with MAX_DSTREAK=0 shows fetch starving.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_streak;

  logic [31:0] iload0, dload0, ramaddr0, ramstore0;
  logic        iwait0, dwait0, ramREN0, ramWEN0;
  logic [1:0]  dbg_state0;
  logic [0:0]  dbg_streak0;

  logic [136:0] exp_q[$];
  string        name_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           fetch0 = 0;
  logic         fair_phase = 1'b0;

  mem_arbiter #(.MAX_DSTREAK(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .dbg_state_o(dbg_state), .dbg_streak_o(dbg_streak)
  );

  mem_arbiter #(.MAX_DSTREAK(0)) dut0 (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload0), .iwait(iwait0),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload0), .dwait(dwait0),
    .ramREN(ramREN0), .ramWEN(ramWEN0), .ramaddr(ramaddr0), .ramstore(ramstore0),
    .ramload(ramload), .ramready(ramready),
    .dbg_state_o(dbg_state0), .dbg_streak_o(dbg_streak0)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver: current inputs are already set; queue expectation, advance a cycle
  task automatic step(input string nm, input logic iw, input logic dw,
                      input logic ren, input logic wen, input logic [31:0] ad,
                      input logic [31:0] sd, input logic [1:0] st, input logic [2:0] sk);
    exp_q.push_back({iw, dw, ren, wen, ad, sd, ramload, ramload, st, sk});
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    logic [136:0] e, a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, dbg_state, dbg_streak};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b addr=%h store=%h iload=%h dload=%h st=%0d sk=%0d; need iw=%b dw=%b ren=%b wen=%b addr=%h store=%h iload=%h dload=%h st=%0d sk=%0d",
                 n, a[136], a[135], a[134], a[133], a[132:101], a[100:69], a[68:37], a[36:5], a[4:3], a[2:0],
                 e[136], e[135], e[134], e[133], e[132:101], e[100:69], e[68:37], e[36:5], e[4:3], e[2:0]);
      end
    end
    if (fair_phase && iREN && !iwait0) fetch0++;
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    @(posedge CLK); #1;

    // reset: idle outputs, then IDLE rules with a fetch pending
    step("reset_idle", 0, 0, 0, 0, 32'h0, 32'h0, 2'd0, 3'd0);
    iREN = 1'b1; iaddr = 32'h40;
    step("reset_ireq", 1, 0, 1, 0, 32'h40, 32'h0, 2'd0, 3'd0);
    nRST = 1'b1;

    // zero-wait fetch
    ramready = 1'b1; ramload = 32'hDEADBEEF;
    step("zw_fetch", 0, 0, 1, 0, 32'h40, 32'h0, 2'd0, 3'd0);

    // data write with 2 stall cycles, fetch waiting
    iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    ramready = 1'b0; ramload = 32'h0;
    step("dw_stall0", 1, 1, 0, 1, 32'h100, 32'h1234, 2'd0, 3'd0);
    step("dw_stall1", 1, 1, 0, 1, 32'h100, 32'h1234, 2'd2, 3'd0);
    ramready = 1'b1;
    step("dw_done",   1, 0, 0, 1, 32'h100, 32'h1234, 2'd2, 3'd0);
    dWEN = 1'b0; ramload = 32'h0000CAFE;
    step("dw_then_i", 0, 0, 1, 0, 32'h44, 32'h0, 2'd0, 3'd1);

    // fetch locked, data arrives and waits
    iaddr = 32'h80; ramready = 1'b0; ramload = 32'h0;
    step("li_req",    1, 0, 1, 0, 32'h80, 32'h0, 2'd0, 3'd0);
    dREN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    step("li_hold",   1, 1, 1, 0, 32'h80, 32'h0, 2'd1, 3'd0);
    ramready = 1'b1; ramload = 32'h11;
    step("li_done",   0, 1, 1, 0, 32'h80, 32'h0, 2'd1, 3'd0);
    iREN = 1'b0; ramload = 32'h22;
    step("li_dserve", 0, 0, 1, 0, 32'h200, 32'h55, 2'd0, 3'd0);

    // fairness: 4 data completions, then 1 fetch, repeating
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400; dstore = 32'h0;
    ramready = 1'b1; ramload = 32'h99;
    fair_phase = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 < 4) step("fair_d", 1, 0, 1, 0, 32'h400, 32'h0, 2'd0, 3'(k % 5));
      else           step("fair_i", 0, 1, 1, 0, 32'h300, 32'h0, 2'd0, 3'd4);
    end
    fair_phase = 1'b0;

    // withdrawal from a data lock
    iaddr = 32'h500; daddr = 32'h600; ramready = 1'b0;
    step("wd_lock",   1, 1, 1, 0, 32'h600, 32'h0, 2'd0, 3'd0);
    dREN = 1'b0;
    step("wd_drop",   1, 0, 0, 0, 32'h0, 32'h0, 2'd2, 3'd0);
    ramready = 1'b1;
    step("wd_fetch",  0, 0, 1, 0, 32'h500, 32'h0, 2'd0, 3'd0);

    // async reset while in LOCK_D with a nonzero streak
    iaddr = 32'h700; dWEN = 1'b1; daddr = 32'h800; dstore = 32'hAB;
    step("ar_dwin",   1, 0, 0, 1, 32'h800, 32'hAB, 2'd0, 3'd0);
    ramready = 1'b0;
    step("ar_lockreq",1, 1, 0, 1, 32'h800, 32'hAB, 2'd0, 3'd1);
    step("ar_locked", 1, 1, 0, 1, 32'h800, 32'hAB, 2'd2, 3'd1);
    nRST = 1'b0;
    step("ar_reset",  1, 1, 0, 1, 32'h800, 32'hAB, 2'd0, 3'd0);
    nRST = 1'b1; dWEN = 1'b0; ramready = 1'b1; ramload = 32'h77;
    step("ar_fetch",  0, 0, 1, 0, 32'h700, 32'h0, 2'd0, 3'd0);

    iREN = 1'b0; ramready = 1'b0;
    @(negedge CLK);
    #1;

    // strict data priority starves fetch
    vectors++;
    if (fetch0 != 0) begin
      miscompares++;
      $display("FAIL starve0: fetch completions got %0d, need 0", fetch0);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: pending expectations got %0d, need 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
